// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: turns one M-stage memory instruction into exactly one
// transaction on the SRAM-like data bus and holds the pipeline until that transaction finishes.
module mem_access_ctrl #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          memenM,
   input  logic          memWriteM,
   input  logic [2:0]    mem_opM,
   input  logic [AW-1:0] addrM,
   input  logic [DW-1:0] wdataM,
   input  logic          flushM,
   input  logic          stall_other,
   output logic          mem_stall,
   output logic [DW-1:0] rdataM,
   output logic          adelM,
   output logic          adesM,
   output logic          data_req,
   output logic          data_wr,
   output logic [1:0]    data_size,
   output logic [AW-1:0] data_addr,
   output logic [3:0]    data_wstrb,
   output logic [DW-1:0] data_wdata,
   input  logic          data_addr_ok,
   input  logic [DW-1:0] data_rdata,
   input  logic          data_data_ok
);

   // S_WAIT means the request was accepted and only the data phase is outstanding.
   // S_DONE parks a finished access while another stall source keeps M frozen, so the
   // same instruction is not issued a second time.
   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } stateT;

   stateT         state;
   stateT         nextState;
   logic          cancel;
   logic          nextCancel;
   logic [DW-1:0] resultReg;

   logic          misaligned;
   logic          start;
   logic          completing;
   logic          discard;
   logic          loadDone;
   logic [7:0]    selByte;
   logic [15:0]   selHalf;
   logic [DW-1:0] loadData;

   // Decode the access size from the op code; byte ops are LB/LBU/SB, halfword ops
   // LH/LHU/SH, and LW/SW are full words.
   always_comb begin
      data_size = 2'd0;
      case (mem_opM)
         3'd0, 3'd1, 3'd5: data_size = 2'd0;
         3'd2, 3'd3, 3'd6: data_size = 2'd1;
         default:          data_size = 2'd2;
      endcase
   end

   // Alignment check only matters for a real memory instruction; the error is routed to
   // the load or store exception flag, and a misaligned access never reaches the bus.
   always_comb begin
      misaligned = 1'b0;
      if (data_size == 2'd1)
         misaligned = addrM[0];
      else if (data_size == 2'd2)
         misaligned = (addrM[1:0] != 2'b00);
      adelM = memenM & misaligned & ~memWriteM;
      adesM = memenM & misaligned & memWriteM;
      start = memenM & ~flushM & ~misaligned;
   end

   // Byte enables follow the low address bits, and write data is replicated across all
   // lanes so the memory can pick whichever lane the strobes enable. Loads get no strobes.
   always_comb begin
      data_wstrb = 4'b0000;
      data_wdata = wdataM;
      case (data_size)
         2'd0: begin
            data_wstrb = 4'b0001 << addrM[1:0];
            data_wdata = {4{wdataM[7:0]}};
         end
         2'd1: begin
            data_wstrb = addrM[1] ? 4'b1100 : 4'b0011;
            data_wdata = {2{wdataM[15:0]}};
         end
         default: begin
            data_wstrb = 4'b1111;
            data_wdata = wdataM;
         end
      endcase
      if (!memWriteM)
         data_wstrb = 4'b0000;
      data_wr   = memWriteM;
      data_addr = addrM;
   end

   // Pick the addressed byte or halfword out of the returned word and extend it;
   // op codes 0 (LB) and 2 (LH) are the sign-extending variants.
   always_comb begin
      selByte  = data_rdata[{addrM[1:0], 3'b000} +: 8];
      selHalf  = addrM[1] ? data_rdata[31:16] : data_rdata[15:0];
      loadData = data_rdata;
      case (mem_opM)
         3'd0:    loadData = {{24{selByte[7]}}, selByte};
         3'd1:    loadData = {24'd0, selByte};
         3'd2:    loadData = {{16{selHalf[15]}}, selHalf};
         3'd3:    loadData = {16'd0, selHalf};
         default: loadData = data_rdata;
      endcase
   end

   // Next-state logic for the bus handshake. A flush that lands after the request was
   // accepted cannot recall it, so it is remembered in cancel and the eventual response is
   // absorbed while the stall stays up. Completions during a flush are discarded the same way.
   always_comb begin
      nextState  = state;
      nextCancel = cancel;
      data_req   = 1'b0;
      mem_stall  = 1'b0;
      completing = 1'b0;
      discard    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               data_req = 1'b1;
               if (data_addr_ok && data_data_ok) begin
                  completing = 1'b1;
                  nextState  = stall_other ? S_DONE : S_IDLE;
               end else begin
                  mem_stall = 1'b1;
                  nextState = data_addr_ok ? S_WAIT : S_REQ;
               end
            end
         end
         S_REQ: begin
            data_req  = 1'b1;
            mem_stall = 1'b1;
            if (data_addr_ok) begin
               if (data_data_ok) begin
                  completing = 1'b1;
                  discard    = flushM;
                  nextState  = (stall_other && !flushM) ? S_DONE : S_IDLE;
               end else begin
                  nextState  = S_WAIT;
                  nextCancel = flushM;
               end
            end else if (flushM) begin
               nextState = S_IDLE;
            end
         end
         S_WAIT: begin
            mem_stall = ~data_data_ok | cancel;
            if (data_data_ok) begin
               completing = 1'b1;
               if (cancel || flushM) begin
                  discard    = 1'b1;
                  nextCancel = 1'b0;
                  nextState  = S_IDLE;
               end else begin
                  nextState = stall_other ? S_DONE : S_IDLE;
               end
            end else if (flushM) begin
               nextCancel = 1'b1;
            end
         end
         S_DONE: begin
            if (!stall_other)
               nextState = S_IDLE;
         end
         default: nextState = S_IDLE;
      endcase
      loadDone = completing & ~discard & ~memWriteM;
      rdataM   = loadDone ? loadData : resultReg;
   end

   // State, cancel flag and the held load result; the result only changes on a
   // completion that was not cancelled, so it stays stable while parked in S_DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cancel    <= 1'b0;
         resultReg <= '0;
      end else begin
         state  <= nextState;
         cancel <= nextCancel;
         if (loadDone)
            resultReg <= loadData;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: drives M-stage controls and bus
// responses cycle by cycle and compares outputs against hand-computed values.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        memenM;
   logic        memWriteM;
   logic [2:0]  mem_opM;
   logic [31:0] addrM;
   logic [31:0] wdataM;
   logic        flushM;
   logic        stall_other;
   logic        mem_stall;
   logic [31:0] rdataM;
   logic        adelM;
   logic        adesM;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic [31:0] data_rdata;
   logic        data_data_ok;

   int testsRun  = 0;
   int failCount = 0;

   mem_access_ctrl #(.AW(32), .DW(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .memenM       (memenM),
      .memWriteM    (memWriteM),
      .mem_opM      (mem_opM),
      .addrM        (addrM),
      .wdataM       (wdataM),
      .flushM       (flushM),
      .stall_other  (stall_other),
      .mem_stall    (mem_stall),
      .rdataM       (rdataM),
      .adelM        (adelM),
      .adesM        (adesM),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_rdata   (data_rdata),
      .data_data_ok (data_data_ok)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Each call is one bus cycle: inputs change at the falling edge, and outputs are
   // sampled 1 ns later, well away from the rising edge that commits the cycle.
   task automatic applyStimulus(input logic en, input logic wr, input logic [2:0] op,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic flush, input logic stallO, input logic aok,
                                input logic dok, input logic [31:0] rdata);
      @(negedge clk);
      memenM       = en;
      memWriteM    = wr;
      mem_opM      = op;
      addrM        = addr;
      wdataM       = wdata;
      flushM       = flush;
      stall_other  = stallO;
      data_addr_ok = aok;
      data_data_ok = dok;
      data_rdata   = rdata;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Linear directed sequence; each block is one scenario with its expected values.
   initial begin
      rst = 1'b1;
      memenM = 1'b0; memWriteM = 1'b0; mem_opM = 3'd0; addrM = '0; wdataM = '0;
      flushM = 1'b0; stall_other = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      data_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
      checkOutput("reset_req",   data_req,  0);
      checkOutput("reset_stall", mem_stall, 0);
      checkOutput("reset_rdata", rdataM,    32'h0);
      checkOutput("reset_adel",  adelM,     0);
      checkOutput("reset_ades",  adesM,     0);

      // LW 0x100: accepted in cycle 1, data in cycle 3
      applyStimulus(1, 0, 3'd4, 32'h100, 32'h0, 0, 0, 0, 0, 32'h0);
      checkOutput("lw_c0_req",   data_req,   1);
      checkOutput("lw_c0_stall", mem_stall,  1);
      checkOutput("lw_c0_size",  data_size,  2);
      checkOutput("lw_c0_wstrb", data_wstrb, 4'b0000);
      checkOutput("lw_c0_wr",    data_wr,    0);
      applyStimulus(1, 0, 3'd4, 32'h100, 32'h0, 0, 0, 1, 0, 32'h0);
      checkOutput("lw_c1_req",   data_req,  1);
      checkOutput("lw_c1_stall", mem_stall, 1);
      applyStimulus(1, 0, 3'd4, 32'h100, 32'h0, 0, 0, 0, 0, 32'h0);
      checkOutput("lw_c2_req",   data_req,  0);
      checkOutput("lw_c2_stall", mem_stall, 1);
      applyStimulus(1, 0, 3'd4, 32'h100, 32'h0, 0, 0, 0, 1, 32'h12345678);
      checkOutput("lw_c3_stall", mem_stall, 0);
      checkOutput("lw_c3_rdata", rdataM,    32'h12345678);
      checkOutput("lw_c3_req",   data_req,  0);
      applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
      checkOutput("lw_hold_rdata", rdataM,   32'h12345678);
      checkOutput("lw_idle_req",   data_req, 0);

      // Single-cycle loads with extension
      applyStimulus(1, 0, 3'd0, 32'h103, 32'h0, 0, 0, 1, 1, 32'h80123456);
      checkOutput("lb_size",  data_size, 0);
      checkOutput("lb_req",   data_req,  1);
      checkOutput("lb_stall", mem_stall, 0);
      checkOutput("lb_rdata", rdataM,    32'hFFFFFF80);
      applyStimulus(1, 0, 3'd1, 32'h103, 32'h0, 0, 0, 1, 1, 32'h80123456);
      checkOutput("lbu_rdata", rdataM, 32'h00000080);
      applyStimulus(1, 0, 3'd2, 32'h102, 32'h0, 0, 0, 1, 1, 32'h80015555);
      checkOutput("lh_rdata", rdataM,    32'hFFFF8001);
      checkOutput("lh_addr",  data_addr, 32'h102);
      checkOutput("lh_size",  data_size, 1);

      // Stores: strobes, replicated data, result register untouched
      applyStimulus(1, 1, 3'd5, 32'h201, 32'hAABBCCDD, 0, 0, 1, 1, 32'h0);
      checkOutput("sb_wr",    data_wr,    1);
      checkOutput("sb_wstrb", data_wstrb, 4'b0010);
      checkOutput("sb_wdata", data_wdata, 32'hDDDDDDDD);
      checkOutput("sb_rdata", rdataM,     32'hFFFF8001);
      applyStimulus(1, 1, 3'd6, 32'h202, 32'hAABBCCDD, 0, 0, 1, 1, 32'h0);
      checkOutput("sh_wstrb", data_wstrb, 4'b1100);
      checkOutput("sh_wdata", data_wdata, 32'hCCDDCCDD);
      applyStimulus(1, 1, 3'd7, 32'h204, 32'hAABBCCDD, 0, 0, 1, 1, 32'h0);
      checkOutput("sw_wstrb", data_wstrb, 4'b1111);
      checkOutput("sw_wdata", data_wdata, 32'hAABBCCDD);

      // Misaligned accesses never reach the bus
      applyStimulus(1, 0, 3'd4, 32'h102, 32'h0, 0, 0, 0, 0, 32'h0);
      checkOutput("mis_lw_adel",  adelM,     1);
      checkOutput("mis_lw_ades",  adesM,     0);
      checkOutput("mis_lw_req",   data_req,  0);
      checkOutput("mis_lw_stall", mem_stall, 0);
      applyStimulus(1, 1, 3'd6, 32'h301, 32'h0, 0, 0, 0, 0, 32'h0);
      checkOutput("mis_sh_ades", adesM,    1);
      checkOutput("mis_sh_adel", adelM,    0);
      checkOutput("mis_sh_req",  data_req, 0);
      applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
      checkOutput("mis_after_req", data_req, 0);

      // Flush while waiting for data: response absorbed, result discarded
      applyStimulus(1, 0, 3'd4, 32'h400, 32'h0, 0, 0, 1, 0, 32'h0);
      checkOutput("fw_req", data_req, 1);
      applyStimulus(1, 0, 3'd4, 32'h400, 32'h0, 1, 0, 0, 0, 32'h0);
      checkOutput("fw_flush_stall", mem_stall, 1);
      checkOutput("fw_flush_req",   data_req,  0);
      applyStimulus(0, 0, 3'd4, 32'h400, 32'h0, 0, 0, 0, 0, 32'h0);
      checkOutput("fw_wait_stall", mem_stall, 1);
      applyStimulus(0, 0, 3'd4, 32'h400, 32'h0, 0, 0, 0, 1, 32'hDEADBEEF);
      checkOutput("fw_dok_stall", mem_stall, 1);
      checkOutput("fw_dok_rdata", rdataM,    32'hFFFF8001);
      applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
      checkOutput("fw_idle_stall", mem_stall, 0);
      checkOutput("fw_idle_req",   data_req,  0);
      checkOutput("fw_idle_rdata", rdataM,    32'hFFFF8001);

      // Flush while request pending: request drops the following cycle
      applyStimulus(1, 0, 3'd4, 32'h500, 32'h0, 0, 0, 0, 0, 32'h0);
      checkOutput("fr_req", data_req, 1);
      applyStimulus(1, 0, 3'd4, 32'h500, 32'h0, 1, 0, 0, 0, 32'h0);
      checkOutput("fr_flush_req", data_req, 1);
      applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
      checkOutput("fr_after_req",   data_req,  0);
      checkOutput("fr_after_stall", mem_stall, 0);

      // Completion under an external stall parks in DONE without re-issuing
      applyStimulus(1, 0, 3'd4, 32'h600, 32'h0, 0, 1, 1, 1, 32'hCAFEF00D);
      checkOutput("dn_c0_stall", mem_stall, 0);
      checkOutput("dn_c0_rdata", rdataM,    32'hCAFEF00D);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 0, 3'd4, 32'h600, 32'h0, 0, 1, 0, 0, 32'h11111111);
         checkOutput("dn_hold_req",   data_req,  0);
         checkOutput("dn_hold_stall", mem_stall, 0);
         checkOutput("dn_hold_rdata", rdataM,    32'hCAFEF00D);
      end
      applyStimulus(1, 0, 3'd4, 32'h600, 32'h0, 0, 0, 0, 0, 32'h11111111);
      checkOutput("dn_release_req",   data_req, 0);
      checkOutput("dn_release_rdata", rdataM,   32'hCAFEF00D);
      applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
      checkOutput("dn_idle_req", data_req, 0);

      // Reset mid-transaction, later bus response ignored
      applyStimulus(1, 0, 3'd4, 32'h700, 32'h0, 0, 0, 0, 0, 32'h0);
      checkOutput("rm_req", data_req, 1);
      @(negedge clk);
      rst = 1'b1;
      memenM = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 0, 3'd4, 32'h700, 32'h0, 0, 0, 1, 1, 32'h55555555);
      checkOutput("rm_req_after",   data_req,  0);
      checkOutput("rm_stall_after", mem_stall, 0);
      checkOutput("rm_rdata_after", rdataM,    32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
